// File: rtl/midi_transmitter.sv
// MIDI transmitter: serialises 1-3 byte messages onto a UART line (8N1, LSB first),
// omitting a repeated channel status byte when running status is enabled.
//
// state | meaning
// IDLE  | line high, ready for the next message
// START | start bit (0) of the current byte
// DATA  | data bits LSB first, bit_idx selects the bit on the line
// STOP  | stop bit (1); chains into the next byte if any remain

module midi_transmitter #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 31250,
  parameter int RUNNING_STATUS  = 1
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [6:0] msg_data1,
  input  logic [6:0] msg_data2,
  input  logic [1:0] msg_length,
  output logic       midi_tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] bit_tmr;
  logic             tmr_tc;
  logic [2:0]       bit_idx;
  logic [1:0]       bytes_left;
  logic [7:0]       cur_byte;
  logic [7:0]       next_byte;
  logic [7:0]       last_byte;
  logic [7:0]       last_status;
  logic             last_valid;
  logic             ready_q;

  logic       is_channel;
  logic       is_common;
  logic       skip_status;
  logic [1:0] n_bytes;
  logic       drop;
  logic       accept;
  logic       launch;

  assign tmr_tc      = (bit_tmr == '0);
  assign msg_ready   = ready_q && (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = msg_valid && msg_ready;

  assign is_channel  = msg_status[7] && (msg_status[7:4] != 4'hF);
  assign is_common   = (msg_status[7:3] == 5'b11110);
  assign skip_status = (RUNNING_STATUS != 0) && is_channel && last_valid &&
                       (last_status == msg_status);
  assign n_bytes     = skip_status ? (msg_length - 2'd1) : msg_length;
  // Malformed, empty and fully-suppressed messages are swallowed without line activity.
  assign drop        = (msg_length == 2'd0) || !msg_status[7] || (n_bytes == 2'd0);
  assign launch      = accept && !drop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = START;
      START:   if (tmr_tc) state_nxt = DATA;
      DATA:    if (tmr_tc && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (tmr_tc) state_nxt = (bytes_left != 2'd0) ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) begin
      midi_tx     <= 1'b1;
      ready_q     <= 1'b0;
      bit_tmr     <= '0;
      bit_idx     <= 3'd0;
      bytes_left  <= 2'd0;
      cur_byte    <= 8'h00;
      next_byte   <= 8'h00;
      last_byte   <= 8'h00;
      last_status <= 8'h00;
      last_valid  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (state != IDLE) bit_tmr <= tmr_tc ? TMR_RELOAD : (bit_tmr - TMR_W'(1));
      case (state)
        IDLE: begin
          if (launch) begin
            midi_tx    <= 1'b0;
            bit_tmr    <= TMR_RELOAD;
            cur_byte   <= skip_status ? {1'b0, msg_data1} : msg_status;
            next_byte  <= skip_status ? {1'b0, msg_data2} : {1'b0, msg_data1};
            last_byte  <= {1'b0, msg_data2};
            bytes_left <= n_bytes - 2'd1;
            // Real-time bytes leave running status alone; system common cancels it.
            if (is_channel) begin
              last_status <= msg_status;
              last_valid  <= 1'b1;
            end else if (is_common) begin
              last_valid  <= 1'b0;
            end
          end
        end
        START: begin
          if (tmr_tc) begin
            midi_tx <= cur_byte[0];
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (tmr_tc) begin
            if (bit_idx == 3'd7) begin
              midi_tx <= 1'b1;
            end else begin
              midi_tx <= cur_byte[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tmr_tc && (bytes_left != 2'd0)) begin
            midi_tx    <= 1'b0;
            cur_byte   <= next_byte;
            next_byte  <= last_byte;
            bytes_left <= bytes_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/midi_transmitter.md
Name: midi_transmitter

Overview:
- Serialises complete MIDI messages onto a 31250-baud UART line: the transmit direction of the existing MIDI receive path.
- Takes 1–3 byte messages over a valid/ready handshake and applies MIDI running status.
- Drives a GPIO pin for MIDI thru/out and for loopback testing of the receiver.
- Runs entirely in the 50 MHz domain.

Parameters:
- CLOCK_FREQUENCY, 50_000_000, input clock frequency in Hz.
- BAUD_RATE, 31250, line bit rate. CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE = 1600.
- RUNNING_STATUS, 1, 1 enables running-status byte omission; 0 always sends the status byte.

Ports:
- clock_50_000_000  input  1  system clock.
- reset_l  input  1  synchronous, active-low reset.
- msg_valid  input  1  message present on msg_* inputs.
- msg_ready  output  1  block can accept a message this cycle.
- msg_status  input  8  status byte; bit 7 must be 1.
- msg_data1  input  7  first data byte.
- msg_data2  input  7  second data byte.
- msg_length  input  2  total message bytes including status: 0–3.
- midi_tx  output  1  UART line; idles high.
- busy  output  1  high while any bit is on the line.

Behaviour:
- Frame per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Data bytes go out with bit 7 = 0.
- Bytes within one message are back-to-back: the next start bit begins on the cycle after the previous stop bit ends.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on accept, when msg_valid && msg_ready at a clock edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits; a 3-bit counter tracks the bit index.
  - STOP → START if bytes remain, else → IDLE.
- msg_ready is high only in IDLE and drops on the accepting edge. busy = (state != IDLE).
- midi_tx is registered. It goes low on the accepting edge.
- After accepting a message of N transmitted bytes, msg_ready returns high exactly N×10×CLKS_PER_BIT cycles later.
- Inputs are captured on accept; later changes on msg_* have no effect.
- Running status (RUNNING_STATUS=1), held in an 8-bit last_status register, valid flag cleared at reset:
  - Channel status 0x80–0xEF equal to a valid last_status: status byte omitted, N = msg_length−1.
  - Channel status 0x80–0xEF otherwise: status byte sent, last_status updated.
  - System common 0xF0–0xF7: status byte sent, last_status invalidated.
  - Real-time 0xF8–0xFF: sent, last_status untouched.
- Drop rules:
  - msg_length = 0 or msg_status[7] = 0: message accepted (one-cycle handshake) and discarded. No line activity, no running-status change, msg_ready stays high.
  - A message whose computed N is 0 is handled the same way.
- Reset, when reset_l is low at an edge:
  - state = IDLE, midi_tx = 1, busy = 0, msg_ready = 0, last_status invalidated.
  - msg_ready rises on the first edge with reset_l high.
  - A reset mid-frame aborts the byte immediately; the line returns high with no partial stop bit.
- Simultaneous events: msg_valid during busy is ignored until IDLE. The sender must hold msg_valid and the data stable until accepted.

Test Plan:
1. Reset idle: hold reset_l low for 5 cycles, then release → midi_tx = 1 and busy = 0 throughout; msg_ready = 0 during reset, 1 on the first edge after release.
2. Note-on: accept {0x90, 0x3C, 0x64}, length 3.
   - Line carries 0x90, 0x3C, 0x64 LSB-first, 10 bits each, 1600 cycles per bit. Start-bit edges are at t = 0, 16000, 32000.
   - msg_ready returns high at t = 48000.
3. Running status: after case 2, send {0x90, 0x40, 0x50} → only 0x40, 0x50 transmitted, ready after 32000 cycles.
   - Then send {0x91, …} → status byte 0x91 is sent.
4. Real-time and system common:
   - After 0x90 established, send F8 (length 1) → one byte sent; a following 0x90 note-on still omits status.
   - Send F6 (length 1), then 0x90 note-on → status byte 0x90 is re-sent.
5. Drops and backpressure:
   - length 0 → accepted in 1 cycle, midi_tx stays high.
   - msg_status = 0x45 → dropped.
   - msg_valid held high through a busy period → second message starts exactly on the cycle after the first finishes.
6. Mid-frame reset: assert reset_l low during DATA bit 3 of 0x90 → midi_tx = 1 on that edge, busy = 0.
   - After release, {0x90, 0x3C, 0x64} sends the full 3 bytes, confirming running status was cleared.
